pool_relu_unit: RTL and testbench

POOL_RELU_UNIT -- requirements
Module: pool_relu_unit

---
 rtl/vgg_pkg.sv | 22 ++
 rtl/pool_line_buf.sv | 33 +++
 rtl/pool_relu_unit.sv | 124 ++++++++++++
 tb/tb_pool_relu_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vgg_pkg.sv
// rtl/vgg_pkg.sv - shared sample format and sizing helpers for the VGG datapath
package vgg_pkg;

    // Width of a MAC result sample, signed two's complement.
    localparam int DATA_W = 16;

    // Pooling window edge; the unit implements 2x2 windows with stride 2.
    localparam int POOL_K = 2;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Counter/address width for n distinct values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Rectify a default-width sample: negative values clamp to zero.
    function automatic sample_t relu(input sample_t x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - one-write one-read line buffer with registered read data
module pool_line_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 112,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // No reset on the array or read register so the buffer maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one horizontal maximum per even-row window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: data stays valid until the next read is issued, so gaps are harmless.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pool_relu_unit.sv
// rtl/pool_relu_unit.sv - streaming ReLU followed by 2x2 stride-2 max pooling
module pool_relu_unit #(
    parameter int DATA_W = vgg_pkg::DATA_W,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int COL_W    = vgg_pkg::cnt_w(IMG_W);
    localparam int ROW_W    = vgg_pkg::cnt_w(IMG_H);
    localparam int LB_DEPTH = IMG_W / vgg_pkg::POOL_K;
    localparam int LB_AW    = vgg_pkg::cnt_w(LB_DEPTH);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic beat;
    logic col_odd;
    logic row_odd;
    logic col_last;
    logic row_last;

    logic signed [DATA_W-1:0] relu_data;
    logic signed [DATA_W-1:0] hold_q;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] vmax;
    logic signed [DATA_W-1:0] out_q;

    logic [DATA_W-1:0] lb_rd_raw;
    logic signed [DATA_W-1:0] lb_rd_data;
    logic [LB_AW-1:0]  lb_addr;
    logic              lb_wr_en;
    logic              lb_rd_en;
    logic              out_fire;

    // clr wins over a coincident beat: that sample is discarded entirely.
    assign beat     = in_valid & ~clr;
    assign col_odd  = col[0];
    assign row_odd  = row[0];
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));

    assign relu_data = in_data[DATA_W-1] ? '0 : $signed(in_data);

    // Horizontal pair maximum, meaningful on the odd-column beat.
    assign hmax = (relu_data > hold_q) ? relu_data : hold_q;

    // Vertical maximum against the stored even-row pair maximum.
    assign lb_rd_data = $signed(lb_rd_raw);
    assign vmax       = (lb_rd_data > hmax) ? lb_rd_data : hmax;

    // Both ports share the pair index; write and read never occur on the same row.
    assign lb_addr  = LB_AW'(col >> 1);
    assign lb_wr_en = beat & ~row_odd &  col_odd;
    assign lb_rd_en = beat &  row_odd & ~col_odd;
    assign out_fire = beat &  row_odd &  col_odd;

    // Raster position, advancing only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (beat) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Hold the even-column rectified sample until its odd-column partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (beat && !col_odd) begin
            hold_q <= relu_data;
        end
    end

    // Registered output stage; out_data keeps its last value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_q      <= '0;
        end else begin
            out_valid  <= out_fire;
            frame_done <= out_fire & row_last & col_last;
            if (out_fire) begin
                out_q <= vmax;
            end
        end
    end

    assign out_data = out_q;

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .ADDR_W (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_raw)
    );

endmodule

// File: tb/tb_pool_relu_unit.sv
// tb/tb_pool_relu_unit.sv - scoreboard bench for pool_relu_unit on a 4x4 frame
module tb_pool_relu_unit;
    import vgg_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        frame_done;

    always #5 clk = ~clk;

    pool_relu_unit #(
        .DATA_W (16),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [15:0] data;
        logic        fd;
        int          cyc;
    } exp_t;

    typedef struct {
        string             name;
        int                kind;
        bit                gaps;
        logic [3:0][15:0]  e;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        got;
    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic sample_t sample_of(input int kind, input int i);
        case (kind)
            0:       return sample_t'(i + 1);
            1:       return sample_t'(16'hFF00);
            2:       return (i == 11) ? sample_t'(16'h7FFF) : sample_t'(1);
            default: return sample_t'(16 - i);
        endcase
    endfunction

    function automatic vec_t mk(input string name, input int kind, input bit gaps,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        vec_t v;
        v.name = name;
        v.kind = kind;
        v.gaps = gaps;
        v.e[0] = a;
        v.e[1] = b;
        v.e[2] = c;
        v.e[3] = d;
        return v;
    endfunction

    // Output monitor: pops the scoreboard on every pulse, checks idle behaviour otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset out_valid", {31'd0, out_valid}, 32'd0);
            check("reset out_data", {16'd0, out_data}, 32'd0);
            check("reset frame_done", {31'd0, frame_done}, 32'd0);
            last_out = '0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious out_valid", 32'd1, 32'd0);
            end else begin
                got = sb_q.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, got.data});
                check("frame_done", {31'd0, frame_done}, {31'd0, got.fd});
                check("latency cycle", cyc, got.cyc);
            end
            last_out = out_data;
        end else begin
            check("idle hold out_data", {16'd0, out_data}, {16'd0, last_out});
            check("idle frame_done", {31'd0, frame_done}, 32'd0);
        end
    end

    // Drive n raster beats of a pattern; push an expectation at each odd-row/odd-col beat.
    task automatic drive(input int kind, input bit gaps, input logic [3:0][15:0] e, input int n);
        int k = 0;
        for (int p = 0; p < n; p++) begin
            int r;
            int c;
            exp_t x;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            r = p / W;
            c = p % W;
            in_data  = sample_of(kind, p);
            in_valid = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                x.data = e[k];
                x.fd   = (r == H - 1) && (c == W - 1);
                x.cyc  = cyc + 1;
                sb_q.push_back(x);
                k++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic settle(input string name);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check(name, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    logic [3:0][15:0] ramp_e;

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ramp_e   = {16'd16, 16'd14, 16'd8, 16'd6};

        vecs[0] = mk("ramp b2b",      0, 1'b0, 16'd6,  16'd8,  16'd14, 16'd16);
        vecs[1] = mk("all negative",  1, 1'b0, 16'd0,  16'd0,  16'd0,  16'd0);
        vecs[2] = mk("ramp gaps",     0, 1'b1, 16'd6,  16'd8,  16'd14, 16'd16);
        vecs[3] = mk("single peak",   2, 1'b0, 16'd1,  16'd1,  16'd1,  16'h7FFF);
        vecs[4] = mk("descend gaps",  3, 1'b1, 16'd16, 16'd14, 16'd8,  16'd6);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].kind, vecs[v].gaps, vecs[v].e, W * H);
            settle({vecs[v].name, " drained"});
        end

        // Reset mid-frame after seven beats; beat six already produced its output.
        drive(0, 1'b0, ramp_e, 7);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("queue empty after reset", sb_q.size(), 32'd0);
        drive(0, 1'b0, ramp_e, W * H);
        settle("reset restart drained");

        // clr coincident with beat three: beat dropped, frame restarts.
        drive(0, 1'b0, ramp_e, 2);
        in_data  = 16'd3;
        in_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        drive(0, 1'b0, ramp_e, W * H);
        settle("clr beat3 drained");

        // clr coincident with a beat that would otherwise emit a pooled output.
        drive(0, 1'b0, ramp_e, 5);
        in_data  = 16'd6;
        in_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        drive(0, 1'b1, ramp_e, W * H);
        settle("clr output beat drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
